// File: rtl/vid_timing_pkg.sv
// Shared types and timing presets for the video timing generator.
// Optional build macro used by the top: VID_TIMING_GEN_FRAME_CNT_EN.
package vid_timing_pkg;

    // Raster coordinates and counters are 12 bit wide (totals up to 4096).
    typedef logic [11:0] coord_t;
    localparam int COORD_MAX_TOTAL = 4096;

    // 1080p60 raster (default)
    localparam int P1080_H_ACTIVE = 1920;
    localparam int P1080_H_FP     = 88;
    localparam int P1080_H_SYNC   = 44;
    localparam int P1080_H_BP     = 148;
    localparam int P1080_V_ACTIVE = 1080;
    localparam int P1080_V_FP     = 4;
    localparam int P1080_V_SYNC   = 5;
    localparam int P1080_V_BP     = 36;

    // 720p60 raster
    localparam int P720_H_ACTIVE  = 1280;
    localparam int P720_H_FP      = 110;
    localparam int P720_H_SYNC    = 40;
    localparam int P720_H_BP      = 220;
    localparam int P720_V_ACTIVE  = 720;
    localparam int P720_V_FP      = 5;
    localparam int P720_V_SYNC    = 5;
    localparam int P720_V_BP      = 20;

    // Sync polarity values
    localparam bit POL_HIGH = 1'b1;
    localparam bit POL_LOW  = 1'b0;

    // Run-control FSM states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } vtc_state_e;

    // Debug view: FSM state plus raster position markers
    typedef struct packed {
        vtc_state_e state;
        logic       line_end;   // h counter at its last position
        logic       frame_end;  // h and v counters both at their last position
    } vtc_dbg_t;

endpackage

// File: rtl/vid_axis_cnt.sv
// One raster axis: wrapping position counter with terminal-count flag and
// sync / active window decode. Segment order is sync, back porch, active,
// front porch, starting at count 0.
module vid_axis_cnt
    import vid_timing_pkg::*;
#(
    parameter int SYNC   = P1080_H_SYNC,
    parameter int BP     = P1080_H_BP,
    parameter int ACTIVE = P1080_H_ACTIVE,
    parameter int FP     = P1080_H_FP
) (
    input  logic   clk_i,
    input  logic   rstn_i,
    input  logic   clr_i,      // hold/return counter to 0 (dominates adv_i)
    input  logic   adv_i,      // advance by one position
    output logic   tc_o,       // counter is at TOTAL-1
    output logic   sync_o,     // counter inside the sync segment
    output logic   active_o,   // counter inside the active segment
    output coord_t pos_o       // counter relative to first active position
);

    localparam int TOTAL = SYNC + BP + ACTIVE + FP;

    // Reject rasters that do not fit the 12-bit counter at elaboration.
    if (TOTAL > COORD_MAX_TOTAL) begin : g_total_chk
        $error("vid_axis_cnt: TOTAL exceeds 4096");
    end

    localparam coord_t      LAST     = coord_t'(TOTAL - 1);
    localparam coord_t      ACT_OFFS = coord_t'(SYNC + BP);
    // Window bounds are one bit wider so an active segment ending at 4096 works.
    localparam logic [12:0] SYNC_END = 13'(SYNC);
    localparam logic [12:0] ACT_LO   = 13'(SYNC + BP);
    localparam logic [12:0] ACT_HI   = 13'(SYNC + BP + ACTIVE);

    coord_t      cnt_q;
    logic [12:0] cnt_w;

    // Position counter: clear dominates, otherwise wrap at the terminal count.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (adv_i) begin
            cnt_q <= tc_o ? '0 : cnt_q + 12'd1;
        end
    end

    // Window decode of the current count.
    always_comb begin
        cnt_w    = {1'b0, cnt_q};
        tc_o     = (cnt_q == LAST);
        sync_o   = (cnt_w < SYNC_END);
        active_o = (cnt_w >= ACT_LO) && (cnt_w < ACT_HI);
        pos_o    = cnt_q - ACT_OFFS;
    end

endmodule

// File: rtl/vid_timing_gen.sv
// Raster timing generator: registered vs/hs/de, active x/y and a frame-start
// pulse for the test pattern generator and later overlay stages.
// Optional build macro: VID_TIMING_GEN_FRAME_CNT_EN adds vtc_frame_cnt_o,
// a 16-bit count of frame-start pulses.
module vid_timing_gen
    import vid_timing_pkg::*;
#(
    parameter int H_ACTIVE = P1080_H_ACTIVE,
    parameter int H_FP     = P1080_H_FP,
    parameter int H_SYNC   = P1080_H_SYNC,
    parameter int H_BP     = P1080_H_BP,
    parameter int V_ACTIVE = P1080_V_ACTIVE,
    parameter int V_FP     = P1080_V_FP,
    parameter int V_SYNC   = P1080_V_SYNC,
    parameter int V_BP     = P1080_V_BP,
    parameter bit HS_POL   = POL_HIGH,
    parameter bit VS_POL   = POL_HIGH
) (
    input  logic        vtc_clk_i,
    input  logic        vtc_rstn_i,
    input  logic        vtc_en_i,
    output logic        vtc_vs_o,
    output logic        vtc_hs_o,
    output logic        vtc_de_o,
    output coord_t      vtc_x_o,
    output coord_t      vtc_y_o,
    output logic        vtc_sof_o,
`ifdef VID_TIMING_GEN_FRAME_CNT_EN
    output logic [15:0] vtc_frame_cnt_o,
`endif
    output vtc_dbg_t    vtc_dbg_o
);

    localparam logic HS_ON  = HS_POL;
    localparam logic HS_OFF = ~HS_POL;
    localparam logic VS_ON  = VS_POL;
    localparam logic VS_OFF = ~VS_POL;

    vtc_state_e state_q, state_d;
    logic       run;
    logic       h_tc, h_sync, h_act;
    logic       v_tc, v_sync, v_act;
    coord_t     h_pos, v_pos;
    logic       de_d;

    // State register.
    always_ff @(posedge vtc_clk_i or negedge vtc_rstn_i) begin
        if (!vtc_rstn_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state follows the sampled enable; counting happens only while
    // RUN is held and enable stays high, so a drop stops output at once.
    always_comb begin
        state_d = state_q;
        run     = 1'b0;
        case (state_q)
            ST_IDLE: if (vtc_en_i) state_d = ST_RUN;
            ST_RUN: begin
                run = vtc_en_i;
                if (!vtc_en_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    vid_axis_cnt #(
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP)
    ) u_h_cnt (
        .clk_i    (vtc_clk_i),
        .rstn_i   (vtc_rstn_i),
        .clr_i    (!run),
        .adv_i    (1'b1),
        .tc_o     (h_tc),
        .sync_o   (h_sync),
        .active_o (h_act),
        .pos_o    (h_pos)
    );

    // Vertical axis steps once per line, on the horizontal wrap.
    vid_axis_cnt #(
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP)
    ) u_v_cnt (
        .clk_i    (vtc_clk_i),
        .rstn_i   (vtc_rstn_i),
        .clr_i    (!run),
        .adv_i    (h_tc),
        .tc_o     (v_tc),
        .sync_o   (v_sync),
        .active_o (v_act),
        .pos_o    (v_pos)
    );

    assign de_d = h_act && v_act;

    // Output registers: decode of the current counters while running,
    // inactive levels otherwise; x/y are forced to 0 outside the window.
    always_ff @(posedge vtc_clk_i or negedge vtc_rstn_i) begin
        if (!vtc_rstn_i) begin
            vtc_hs_o  <= HS_OFF;
            vtc_vs_o  <= VS_OFF;
            vtc_de_o  <= 1'b0;
            vtc_x_o   <= '0;
            vtc_y_o   <= '0;
            vtc_sof_o <= 1'b0;
        end else if (run) begin
            vtc_hs_o  <= h_sync ? HS_ON : HS_OFF;
            vtc_vs_o  <= v_sync ? VS_ON : VS_OFF;
            vtc_de_o  <= de_d;
            vtc_x_o   <= de_d ? h_pos : '0;
            vtc_y_o   <= de_d ? v_pos : '0;
            vtc_sof_o <= de_d && (h_pos == '0) && (v_pos == '0);
        end else begin
            vtc_hs_o  <= HS_OFF;
            vtc_vs_o  <= VS_OFF;
            vtc_de_o  <= 1'b0;
            vtc_x_o   <= '0;
            vtc_y_o   <= '0;
            vtc_sof_o <= 1'b0;
        end
    end

    // Debug view of the FSM and raster position.
    always_comb begin
        vtc_dbg_o.state     = state_q;
        vtc_dbg_o.line_end  = h_tc;
        vtc_dbg_o.frame_end = h_tc && v_tc;
    end

`ifdef VID_TIMING_GEN_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Frame counter: one step per frame-start pulse, held while idle.
    always_ff @(posedge vtc_clk_i or negedge vtc_rstn_i) begin
        if (!vtc_rstn_i) begin
            frame_cnt_q <= '0;
        end else if (vtc_sof_o) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign vtc_frame_cnt_o = frame_cnt_q;
`endif

endmodule
